// File: rtl/line_fill_buffer.sv
// Line fill buffer: on a data-cache miss it fetches an 8-word line from memory.
// The fetch can run critical-word-first with wrap (CWF=1) or in plain order from word 0 (CWF=0).
module line_fill_buffer #(
  parameter int CWF = 1
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         LB_Enable,
  input  logic [31:0]  Req_Addr,
  output logic         LB_FirstWord,
  output logic         LB_Completed,
  output logic [255:0] LB_LineData,
  output logic [31:0]  LB_LineAddr,
  output logic         Mem_Req,
  output logic [31:0]  Mem_Addr,
  input  logic         Mem_Ack,
  input  logic [31:0]  Mem_RData
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FILL = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]   r_state;
  logic [28:0]  r_lineTag;
  logic [2:0]   r_reqIdx;
  logic [2:0]   r_start;
  logic [2:0]   r_count;
  logic [255:0] r_line;
  logic         r_firstWord;

  logic         w_accept;
  logic         w_capture;
  logic         w_lastWord;
  logic [2:0]   w_idx;

  assign w_accept   = (r_state == IDLE) && LB_Enable;
  assign w_capture  = (r_state == FILL) && Mem_Ack;
  assign w_lastWord = w_capture && (r_count == 3'd7);
  // The 3-bit sum wraps naturally, giving the critical-word-first order.
  assign w_idx      = r_start + r_count;

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_accept) r_state <= FILL;
        FILL:    if (w_lastWord) r_state <= DONE;
        DONE:    if (!LB_Enable) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // The request is sampled only at accept, so address changes during a fill are ignored.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_lineTag <= 29'd0;
      r_reqIdx  <= 3'd0;
      r_start   <= 3'd0;
      r_count   <= 3'd0;
    end else if (w_accept) begin
      r_lineTag <= Req_Addr[31:3];
      r_reqIdx  <= Req_Addr[2:0];
      r_start   <= (CWF != 0) ? Req_Addr[2:0] : 3'd0;
      r_count   <= 3'd0;
    end else if (w_capture) begin
      r_count   <= r_count + 3'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_line <= 256'd0;
    end else if (w_capture) begin
      r_line[{w_idx, 5'd0} +: 32] <= Mem_RData;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_firstWord <= 1'b0;
    end else begin
      r_firstWord <= w_capture && (w_idx == r_reqIdx);
    end
  end

  assign Mem_Req      = (r_state == FILL);
  assign Mem_Addr     = Mem_Req ? {r_lineTag, w_idx} : 32'd0;
  assign LB_Completed = (r_state == DONE);
  assign LB_LineData  = r_line;
  assign LB_LineAddr  = {r_lineTag, 3'b000};
  assign LB_FirstWord = r_firstWord;

endmodule

// File: tb/tb_line_fill_buffer.sv
// Directed bench for line_fill_buffer: a table of per-cycle vectors for the CWF=1 fill,
// plus hand-written sequences for CWF=0 ordering, slow acks and reset mid-fill.
module tb_line_fill_buffer;

  logic         Clk;
  logic         Rst;
  logic         LB_Enable;
  logic [31:0]  Req_Addr;
  logic         Mem_Ack;

  logic         first1, done1, req1;
  logic [255:0] line1;
  logic [31:0]  lineAddr1, memAddr1, rdata1;
  logic         first0, done0, req0;
  logic [255:0] line0;
  logic [31:0]  lineAddr0, memAddr0, rdata0;

  int compared   = 0;
  int mismatched = 0;

  // Memory returns a word tagged with its own address.
  assign rdata1 = 32'hA000_0000 | memAddr1;
  assign rdata0 = 32'hA000_0000 | memAddr0;

  line_fill_buffer #(.CWF(1)) dut1 (
    .Clk(Clk), .Rst(Rst), .LB_Enable(LB_Enable), .Req_Addr(Req_Addr),
    .LB_FirstWord(first1), .LB_Completed(done1), .LB_LineData(line1),
    .LB_LineAddr(lineAddr1), .Mem_Req(req1), .Mem_Addr(memAddr1),
    .Mem_Ack(Mem_Ack), .Mem_RData(rdata1)
  );

  line_fill_buffer #(.CWF(0)) dut0 (
    .Clk(Clk), .Rst(Rst), .LB_Enable(LB_Enable), .Req_Addr(Req_Addr),
    .LB_FirstWord(first0), .LB_Completed(done0), .LB_LineData(line0),
    .LB_LineAddr(lineAddr0), .Mem_Req(req0), .Mem_Addr(memAddr0),
    .Mem_Ack(Mem_Ack), .Mem_RData(rdata0)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        en;
    logic        ack;
    logic [31:0] addr;
    logic        expReq;
    logic [31:0] expMemAddr;
    logic        expFirst;
    logic        expDone;
    logic [31:0] expLineAddr;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(logic en, logic ack, logic [31:0] addr, logic expReq,
                              logic [31:0] expMemAddr, logic expFirst, logic expDone,
                              logic [31:0] expLineAddr);
    vec_t v;
    v.en = en; v.ack = ack; v.addr = addr; v.expReq = expReq;
    v.expMemAddr = expMemAddr; v.expFirst = expFirst; v.expDone = expDone;
    v.expLineAddr = expLineAddr;
    return v;
  endfunction

  // Drive inputs, then sample #1 after the following rising edge.
  task automatic applyStimulus(input logic en, input logic ack, input logic [31:0] addr);
    LB_Enable = en;
    Mem_Ack   = ack;
    Req_Addr  = addr;
    @(posedge Clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkLine(input string name, input logic [255:0] line, input logic [31:0] base);
    for (int i = 0; i < 8; i++) begin
      logic [31:0] expWord;
      expWord = 32'hA000_0000 | base | i;
      checkOutput($sformatf("%s_word%0d", name, i), {224'd0, line[i*32 +: 32]}, {224'd0, expWord});
    end
  endtask

  initial begin
    bit seen;
    vecs[0]  = mk(1'b1, 1'b1, 32'h105, 1'b1, 32'h105, 1'b0, 1'b0, 32'h100);
    vecs[1]  = mk(1'b1, 1'b1, 32'h3FF, 1'b1, 32'h106, 1'b1, 1'b0, 32'h100);
    vecs[2]  = mk(1'b0, 1'b1, 32'h0F0, 1'b1, 32'h107, 1'b0, 1'b0, 32'h100);
    vecs[3]  = mk(1'b1, 1'b1, 32'h105, 1'b1, 32'h100, 1'b0, 1'b0, 32'h100);
    vecs[4]  = mk(1'b1, 1'b1, 32'h105, 1'b1, 32'h101, 1'b0, 1'b0, 32'h100);
    vecs[5]  = mk(1'b1, 1'b1, 32'h105, 1'b1, 32'h102, 1'b0, 1'b0, 32'h100);
    vecs[6]  = mk(1'b1, 1'b1, 32'h105, 1'b1, 32'h103, 1'b0, 1'b0, 32'h100);
    vecs[7]  = mk(1'b1, 1'b1, 32'h105, 1'b1, 32'h104, 1'b0, 1'b0, 32'h100);
    vecs[8]  = mk(1'b1, 1'b1, 32'h105, 1'b0, 32'h000, 1'b0, 1'b1, 32'h100);
    vecs[9]  = mk(1'b1, 1'b1, 32'h200, 1'b0, 32'h000, 1'b0, 1'b1, 32'h100);
    vecs[10] = mk(1'b1, 1'b1, 32'h200, 1'b0, 32'h000, 1'b0, 1'b1, 32'h100);
    vecs[11] = mk(1'b1, 1'b1, 32'h200, 1'b0, 32'h000, 1'b0, 1'b1, 32'h100);
    vecs[12] = mk(1'b1, 1'b1, 32'h200, 1'b0, 32'h000, 1'b0, 1'b1, 32'h100);
    vecs[13] = mk(1'b1, 1'b1, 32'h200, 1'b0, 32'h000, 1'b0, 1'b1, 32'h100);
    vecs[14] = mk(1'b0, 1'b0, 32'h200, 1'b0, 32'h000, 1'b0, 1'b0, 32'h100);
    vecs[15] = mk(1'b0, 1'b1, 32'h777, 1'b0, 32'h000, 1'b0, 1'b0, 32'h100);

    Rst = 1'b0;
    applyStimulus(1'b1, 1'b1, 32'h105);
    applyStimulus(1'b1, 1'b1, 32'h105);
    checkOutput("reset_req",      {255'd0, req1},  256'd0);
    checkOutput("reset_memaddr",  {224'd0, memAddr1}, 256'd0);
    checkOutput("reset_done",     {255'd0, done1}, 256'd0);
    checkOutput("reset_first",    {255'd0, first1}, 256'd0);
    checkOutput("reset_line",     line1, 256'd0);
    checkOutput("reset_lineaddr", {224'd0, lineAddr1}, 256'd0);
    Rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0);

    // CWF=1 fill with ack tied high, then done-hold and return to idle.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].en, vecs[i].ack, vecs[i].addr);
      checkOutput($sformatf("v%0d_req", i),      {255'd0, req1},      {255'd0, vecs[i].expReq});
      checkOutput($sformatf("v%0d_memaddr", i),  {224'd0, memAddr1},  {224'd0, vecs[i].expMemAddr});
      checkOutput($sformatf("v%0d_first", i),    {255'd0, first1},    {255'd0, vecs[i].expFirst});
      checkOutput($sformatf("v%0d_done", i),     {255'd0, done1},     {255'd0, vecs[i].expDone});
      checkOutput($sformatf("v%0d_lineaddr", i), {224'd0, lineAddr1}, {224'd0, vecs[i].expLineAddr});
    end
    checkLine("cwf1_line", line1, 32'h100);

    // CWF=0: plain order, first-word pulse after the sixth ack.
    applyStimulus(1'b1, 1'b0, 32'h105);
    checkOutput("cwf0_start_addr", {224'd0, memAddr0}, {224'd0, 32'h100});
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, 1'b1, 32'h105);
      checkOutput($sformatf("cwf0_first_%0d", k), {255'd0, first0}, {255'd0, (k == 5)});
      if (k < 7)
        checkOutput($sformatf("cwf0_addr_%0d", k), {224'd0, memAddr0}, {224'd0, 32'h100 + k + 1});
    end
    checkOutput("cwf0_done", {255'd0, done0}, {255'd0, 1'b1});
    checkOutput("cwf0_req_off", {255'd0, req0}, 256'd0);
    checkOutput("cwf0_lineaddr", {224'd0, lineAddr0}, {224'd0, 32'h100});
    checkLine("cwf0_line", line0, 32'h100);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("cwf0_idle", {255'd0, done0}, 256'd0);

    // Ack every third cycle: address must hold between acks.
    applyStimulus(1'b1, 1'b0, 32'h105);
    for (int k = 0; k < 8; k++) begin
      logic [31:0] expA;
      expA = 32'h100 | ((5 + k) % 8);
      for (int s = 0; s < 2; s++) begin
        applyStimulus(1'b1, 1'b0, 32'h0ABC_0000);
        checkOutput($sformatf("slow_hold_%0d_%0d", k, s), {224'd0, memAddr1}, {224'd0, expA});
      end
      applyStimulus(1'b1, 1'b1, 32'h0ABC_0000);
    end
    checkOutput("slow_done", {255'd0, done1}, {255'd0, 1'b1});
    checkLine("slow_line", line1, 32'h100);
    applyStimulus(1'b0, 1'b0, 32'h0);

    // Reset after three acks abandons the fill; a new fill then starts cleanly.
    applyStimulus(1'b1, 1'b0, 32'h105);
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1, 32'h105);
    Rst = 1'b0;
    applyStimulus(1'b0, 1'b1, 32'h105);
    Rst = 1'b1;
    checkOutput("rst_req",      {255'd0, req1}, 256'd0);
    checkOutput("rst_line",     line1, 256'd0);
    checkOutput("rst_lineaddr", {224'd0, lineAddr1}, 256'd0);
    checkOutput("rst_memaddr",  {224'd0, memAddr1}, 256'd0);
    applyStimulus(1'b1, 1'b0, 32'h208);
    checkOutput("refill_addr1", {224'd0, memAddr1}, {224'd0, 32'h208});
    checkOutput("refill_addr0", {224'd0, memAddr0}, {224'd0, 32'h208});
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      applyStimulus(1'b0, 1'b1, 32'h208);
      seen = done1;
    end
    checkOutput("refill_done", {255'd0, seen}, {255'd0, 1'b1});
    checkOutput("refill_lineaddr", {224'd0, lineAddr1}, {224'd0, 32'h208});
    checkLine("refill_line", line1, 32'h208);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("refill_idle", {255'd0, done1}, 256'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
